ahblite_decode_mux: RTL and testbench
=====================================

# ahblite_decode_mux

Parametrised AHB-Lite address decoder plus slave-response multiplexer with a built-in default slave, placed between the Cortex-M0 master and its NPORT peripheral/memory slaves. It decodes each address phase against per-port base/mask pairs and drives one-hot HSEL. It registers the selection for the data phase and muxes HREADY/HRDATA/HRESP back to the master. Unmapped transfers are answered with the two-cycle AHB ERROR response.

## Interface
- NPORT, 5, number of slave ports (1–16)
- PORT_BASE, {0x40000020,0x40000010,0x40000000,0x20000000,0x00000000}, NPORT×32 packed base addresses, port i at bits [32i+31:32i]
- PORT_MASK, {0xFFFFFFF0,0xFFFFFFF0,0xFFFFFFF0,0xFFFF0000,0xFFFF0000}, NPORT×32 packed masks
- PORT_EN, all ones, NPORT-bit enable; a cleared bit makes that port never selected

- HCLK  in  1  bus clock
- HRESETn  in  1  asynchronous active-low reset
- HADDR  in  32  master address
- HTRANS  in  2  master transfer type
- HSEL_P  out  NPORT  one-hot address-phase slave select
- HREADY  out  1  muxed ready, to master and all slaves
- HRDATA  out  32  muxed read data to master
- HRESP  out  1  muxed response to master
- HREADYOUT_P  in  NPORT  per-slave ready
- HRDATA_P  in  NPORT×32  per-slave read data
- HRESP_P  in  NPORT  per-slave response

## Operation
- Hit for port i: PORT_EN[i] && ((HADDR & PORT_MASK[i]) == PORT_BASE[i]).
- Lowest index wins on overlap, so HSEL_P is always one-hot or zero.
- HSEL_P is combinational from HADDR regardless of HTRANS. Slaves qualify it with HTRANS/HREADY.
- Data-phase select register dsel, NPORT+1 states: port 0..NPORT-1 or DEFAULT. It loads the decode result only when HREADY=1.
- Port i in data phase:
  - HREADY=HREADYOUT_P[i]
  - HRDATA=HRDATA_P[i]
  - HRESP=HRESP_P[i]
- DEFAULT with no error pending: HREADY=1, HRESP=0, HRDATA=0.
- Default-slave FSM states IDLE, ERR1, ERR2.
  - IDLE→ERR1 when HREADY=1, no port hit, and HTRANS[1]=1 (NONSEQ/SEQ).
  - ERR1→ERR2 unconditionally.
  - ERR2→ERR1 if the next sampled transfer is again an unmapped NONSEQ/SEQ; otherwise ERR2→IDLE.
- Output in ERR1: HREADY=0, HRESP=1. Output in ERR2: HREADY=1, HRESP=1. HRDATA=0 in both.
- IDLE or BUSY transfers to unmapped addresses get a zero-wait OKAY.
- HTRANS changes during ERR1 are ignored; the address is sampled only when HREADY=1.

## Timing
- Reset values (asynchronous on HRESETn low): dsel=DEFAULT, FSM=IDLE, HREADY=1, HRESP=0, HRDATA=0.
- HSEL_P still follows HADDR during reset.
- Reset asserted mid-ERR1/ERR2 returns the block to the reset values immediately. There is no pending error after release.
- Decode latency: 0 cycles, address phase. Response mux is valid in the cycle after the address is accepted.
- Unmapped NONSEQ costs exactly 2 data-phase cycles.
- A slave wait state (HREADYOUT_P=0) holds dsel. A new address is not accepted until HREADY=1.

## Configuration
- AHBLITE_DECODE_ERR_EN
  - Defined: default-slave FSM present, behaving as described above.
  - Undefined: FSM removed. Unmapped transfers of any type return HREADY=1, HRESP=0, HRDATA=0 in one cycle.

## Test plan
- Reset with HADDR=0x20000004: HSEL_P=5'b00010, HREADY=1, HRESP=0, HRDATA=0.
- NONSEQ to 0x40000014, then port 3 returns HRDATA_P=0xA5A5_0001 with HREADYOUT_P[3]=1: HSEL_P=5'b01000 and HRDATA=0xA5A50001 one cycle later.
- NONSEQ to 0x40000004 with HREADYOUT_P[2] low for 3 cycles: HREADY low exactly 3 cycles. A new HADDR presented during the wait is not loaded into dsel.
- NONSEQ to unmapped 0x50000000:
  - HSEL_P=0.
  - Next cycle HREADY=0/HRESP=1, following cycle HREADY=1/HRESP=1, then IDLE.
  - Repeat as back-to-back unmapped transfers: ERR2→ERR1 chaining.
  - With the macro undefined: single cycle, HREADY=1/HRESP=0.
- IDLE HTRANS to 0x50000000: HREADY=1, HRESP=0, with no error cycle.
- HRESETn pulsed low during ERR1: HREADY=1 and HRESP=0 immediately. The next mapped NONSEQ to 0x00000100 completes with OKAY.

Source files
------------

// File: rtl/ahblite_decode_mux.sv
// ahblite_decode_mux: AHB-Lite address decoder and slave-response multiplexer
// with a built-in default slave for unmapped transfers.
//
// Ports:
//   HCLK, HRESETn     bus clock, asynchronous active-low reset
//   HADDR, HTRANS     master address-phase signals
//   HSEL_P            one-hot address-phase select (combinational from HADDR)
//   HREADY            muxed ready to master and all slaves
//   HRDATA, HRESP     muxed read data / response to master
//   HREADYOUT_P       per-slave ready
//   HRDATA_P          per-slave read data, port i at [32i+31:32i]
//   HRESP_P           per-slave response
//
// Configuration macro: AHBLITE_DECODE_ERR_EN
//   defined   - default slave answers unmapped NONSEQ/SEQ with a two-cycle ERROR
//   undefined - unmapped transfers of any type get a zero-wait OKAY
module ahblite_decode_mux #(
  parameter int unsigned         NPORT     = 5,
  parameter logic [NPORT*32-1:0] PORT_BASE = {32'h4000_0020, 32'h4000_0010, 32'h4000_0000,
                                              32'h2000_0000, 32'h0000_0000},
  parameter logic [NPORT*32-1:0] PORT_MASK = {32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFF0,
                                              32'hFFFF_0000, 32'hFFFF_0000},
  parameter logic [NPORT-1:0]    PORT_EN   = '1
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic [31:0]         HADDR,
  input  logic [1:0]          HTRANS,
  output logic [NPORT-1:0]    HSEL_P,
  output logic                HREADY,
  output logic [31:0]         HRDATA,
  output logic                HRESP,
  input  logic [NPORT-1:0]    HREADYOUT_P,
  input  logic [NPORT*32-1:0] HRDATA_P,
  input  logic [NPORT-1:0]    HRESP_P
);

  localparam int unsigned SELW = $clog2(NPORT + 1);
  localparam logic [SELW-1:0] SEL_DEFAULT = SELW'(NPORT);

  logic [SELW-1:0] hit_idx;
  logic            any_hit;
  logic [SELW-1:0] dsel_q, dsel_d;

  // HTRANS[0] never affects decode; HTRANS is entirely unused without the FSM.
  logic unused_htrans;
  assign unused_htrans = ^HTRANS;

  // Address decode, lowest index wins on overlap.
  always_comb begin
    HSEL_P  = '0;
    hit_idx = SEL_DEFAULT;
    any_hit = 1'b0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      if (!any_hit && PORT_EN[i] &&
          ((HADDR & PORT_MASK[32*i +: 32]) == PORT_BASE[32*i +: 32])) begin
        HSEL_P[i] = 1'b1;
        hit_idx   = SELW'(i);
        any_hit   = 1'b1;
      end
    end
  end

  // Data-phase select only advances when the current transfer completes.
  always_comb begin
    dsel_d = dsel_q;
    if (HREADY) begin
      dsel_d = hit_idx;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dsel_q <= SEL_DEFAULT;
    end else begin
      dsel_q <= dsel_d;
    end
  end

`ifdef AHBLITE_DECODE_ERR_EN
  typedef enum logic [1:0] {
    S_IDLE,
    S_ERR1,
    S_ERR2
  } err_state_e;

  err_state_e state_q, state_d;
  logic       err_start;

  // Default-slave FSM: two-cycle ERROR for unmapped NONSEQ/SEQ.
  always_comb begin
    state_d   = state_q;
    err_start = HREADY && !any_hit && HTRANS[1];
    case (state_q)
      S_IDLE:  if (err_start) state_d = S_ERR1;
      S_ERR1:  state_d = S_ERR2;
      S_ERR2:  state_d = err_start ? S_ERR1 : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end
`endif

  // Response mux; default slave answers when dsel is DEFAULT.
  always_comb begin
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = '0;
`ifdef AHBLITE_DECODE_ERR_EN
    case (state_q)
      S_ERR1: begin
        HREADY = 1'b0;
        HRESP  = 1'b1;
      end
      S_ERR2: begin
        HREADY = 1'b1;
        HRESP  = 1'b1;
      end
      default: ;
    endcase
`endif
    for (int unsigned i = 0; i < NPORT; i++) begin
      if (dsel_q == SELW'(i)) begin
        HREADY = HREADYOUT_P[i];
        HRESP  = HRESP_P[i];
        HRDATA = HRDATA_P[32*i +: 32];
      end
    end
  end

endmodule

// File: tb/tb_ahblite_decode_mux.sv
// Self-checking bench for ahblite_decode_mux: directed steps followed by
// randomized traffic, all checked against a transfer-level reference model.
module tb_ahblite_decode_mux;

  localparam int NP = 5;
`ifdef AHBLITE_DECODE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic           HCLK = 1'b0;
  logic           HRESETn;
  logic [31:0]    HADDR;
  logic [1:0]     HTRANS;
  logic [NP-1:0]  HSEL_P;
  logic           HREADY;
  logic [31:0]    HRDATA;
  logic           HRESP;
  logic [NP-1:0]  HREADYOUT_P;
  logic [NP*32-1:0] HRDATA_P;
  logic [NP-1:0]  HRESP_P;

  logic [31:0] sd [NP];

  always #5 HCLK = ~HCLK;

  always_comb begin
    for (int i = 0; i < NP; i++) HRDATA_P[32*i +: 32] = sd[i];
  end

  ahblite_decode_mux dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .HADDR       (HADDR),
    .HTRANS      (HTRANS),
    .HSEL_P      (HSEL_P),
    .HREADY      (HREADY),
    .HRDATA      (HRDATA),
    .HRESP       (HRESP),
    .HREADYOUT_P (HREADYOUT_P),
    .HRDATA_P    (HRDATA_P),
    .HRESP_P     (HRESP_P)
  );

  // Memory map as written in the specification.
  logic [31:0] base [NP] = '{32'h0000_0000, 32'h2000_0000, 32'h4000_0000,
                             32'h4000_0010, 32'h4000_0020};
  logic [31:0] mask [NP] = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_FFF0,
                             32'hFFFF_FFF0, 32'hFFFF_FFF0};

  // Model state: data-phase target (-1 = default slave) and error-response
  // cycle number (0 = none, 1 = first wait cycle, 2 = final cycle).
  int tgt;
  int errph;
  int n_cmp;
  int n_fail;
  logic seen_rdy;

  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

  function automatic int decode(logic [31:0] a);
    for (int i = 0; i < NP; i++) begin
      if ((a & mask[i]) == base[i]) return i;
    end
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive at posedge+1, check at posedge+3, advance model.
  task automatic step(input logic [31:0] a, input logic [1:0] t,
                      input logic [NP-1:0] rdy, input logic [NP-1:0] rsp);
    int d;
    logic [NP-1:0] esel;
    logic erdy, ersp;
    logic [31:0] edat;
    HADDR = a;
    HTRANS = t;
    HREADYOUT_P = rdy;
    HRESP_P = rsp;
    #2;
    d = decode(a);
    esel = '0;
    if (d >= 0) esel[d] = 1'b1;
    if (tgt >= 0) begin
      erdy = rdy[tgt];
      ersp = rsp[tgt];
      edat = sd[tgt];
    end else begin
      erdy = (errph != 1);
      ersp = (errph != 0);
      edat = 32'h0;
    end
    check("hsel",   32'(HSEL_P), 32'(esel));
    check("hready", 32'(HREADY), 32'(erdy));
    check("hresp",  32'(HRESP),  32'(ersp));
    check("hrdata", HRDATA, edat);
    seen_rdy = HREADY;
    @(posedge HCLK);
    #1;
    if (erdy) begin
      tgt   = d;
      errph = (d < 0 && t[1] && ERR_EN) ? 1 : 0;
    end else if (errph == 1) begin
      errph = 2;
    end
  endtask

  task automatic reset_pulse();
    int d;
    logic [NP-1:0] esel;
    HRESETn = 1'b0;
    #2;
    d = decode(HADDR);
    esel = '0;
    if (d >= 0) esel[d] = 1'b1;
    check("rst_hsel",   32'(HSEL_P), 32'(esel));
    check("rst_hready", 32'(HREADY), 32'h1);
    check("rst_hresp",  32'(HRESP),  32'h0);
    check("rst_hrdata", HRDATA, 32'h0);
    tgt = -1;
    errph = 0;
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
  endtask

  initial begin
    int low_cnt;
    int k;
    logic [31:0] a;
    n_cmp = 0;
    n_fail = 0;
    tgt = -1;
    errph = 0;
    HRESETn = 1'b1;
    HADDR = 32'h2000_0004;
    HTRANS = T_IDLE;
    HREADYOUT_P = '1;
    HRESP_P = '0;
    for (int i = 0; i < NP; i++) sd[i] = 32'h0;
    #1;
    HRESETn = 1'b0;
    #2;
    check("reset_hsel",   32'(HSEL_P), 32'h0000_0002);
    check("reset_hready", 32'(HREADY), 32'h1);
    check("reset_hresp",  32'(HRESP),  32'h0);
    check("reset_hrdata", HRDATA, 32'h0);
    repeat (2) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;

    // Read from port 3.
    for (int i = 0; i < NP; i++) sd[i] = 32'h1111_0000 + 32'(i);
    sd[3] = 32'hA5A5_0001;
    step(32'h4000_0014, T_NSEQ, '1, '0);
    step(32'h2000_0000, T_IDLE, '1, '0);
    check("p3_rdata_seen", HRDATA, 32'h1111_0001);

    // Port 2 with three wait states; a changed address must not load dsel.
    step(32'h4000_0004, T_NSEQ, '1, '0);
    low_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step(32'h0000_0100, T_NSEQ, 5'b11011, '0);
      if (!seen_rdy) low_cnt++;
    end
    step(32'h0000_0100, T_NSEQ, '1, '0);
    if (!seen_rdy) low_cnt++;
    check("wait_low_cycles", 32'(low_cnt), 32'd3);
    step(32'h0000_0000, T_IDLE, '1, '0);

    // Unmapped NONSEQ, then back-to-back unmapped chaining.
    step(32'h5000_0000, T_NSEQ, '1, '0);
    step(32'h5000_0000, T_IDLE, '1, '0);
    step(32'h5000_0000, T_IDLE, '1, '0);
    step(32'h5000_0000, T_IDLE, '1, '0);
    step(32'h5000_0000, T_NSEQ, '1, '0);
    step(32'h5000_0000, T_SEQ,  '1, '0);
    step(32'h5000_0000, T_SEQ,  '1, '0);
    step(32'h5000_0000, T_IDLE, '1, '0);
    step(32'h5000_0000, T_IDLE, '1, '0);
    step(32'h5000_0000, T_IDLE, '1, '0);

    // IDLE/BUSY to unmapped space: zero-wait OKAY.
    step(32'h5000_0000, T_IDLE, '1, '0);
    step(32'h5000_0000, T_BUSY, '1, '0);
    step(32'h0000_0000, T_IDLE, '1, '0);

    // Reset in the middle of an error response.
    step(32'h5000_0000, T_NSEQ, '1, '0);
    reset_pulse();
    sd[0] = 32'h0BAD_CAFE;
    step(32'h0000_0100, T_NSEQ, '1, '0);
    step(32'h0000_0000, T_IDLE, '1, '0);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      logic [NP-1:0] rdy;
      for (int i = 0; i < NP; i++) begin
        sd[i] = $urandom;
        rdy[i] = ($urandom_range(0, 3) != 0);
      end
      k = $urandom_range(0, NP);
      if (k < NP) a = base[k] | ($urandom & ~mask[k]);
      else        a = $urandom;
      if ($urandom_range(0, 60) == 0) reset_pulse();
      else step(a, 2'($urandom_range(0, 3)), rdy, NP'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
